// File: rtl/game_pkg.sv
// game_pkg: shared game-state encoding, screen constants and LFSR settings
// used by the referee and other random-placement blocks.
package game_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StOver,
        StWin
    } game_state_e;

    localparam int unsigned ScreenW = 640;
    localparam int unsigned ScreenH = 480;

    localparam logic [7:0] LfsrSeed = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1, right-shifting Galois form
    localparam logic [7:0] LfsrTaps = 8'hB8;

    // Low 7 bits of v rotated left by n positions.
    function automatic logic [6:0] rot_low7(input logic [7:0] v, input int unsigned n);
        logic [6:0] r;
        for (int b = 0; b < 7; b++) begin
            r[b] = v[3'((32'(b) + 32'd8 - (n % 32'd8)) % 32'd8)];
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Galois LFSR; loads seed on reset, steps when en is high.
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] state
);

    logic [7:0] state_q, state_d;

    // Next value: shift right, fold taps back in when a one falls out.
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {1'b0, state_q[7:1]} ^ (state_q[0] ? LfsrTaps : 8'h00);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pipe_referee.sv
// pipe_referee: frame-rate referee. Scrolls NUM_PIPES pipe columns, tests the
// ball box against the pipes and the floor, counts passes and runs the
// IDLE/PLAY/OVER/WIN state machine.
// Optional feature macro: PIPE_SPEEDUP_EN (scroll speed grows with score).
module pipe_referee
    import game_pkg::*;
#(
    parameter int unsigned NUM_PIPES    = 3,
    parameter int unsigned PIPE_W       = 40,
    parameter int unsigned GAP_H        = 120,
    parameter int unsigned GAP_MIN      = 100,
    parameter int unsigned PIPE_SPACING = 220,
    parameter int unsigned SCROLL_STEP  = 2,
    parameter int unsigned SCREEN_W     = ScreenW,
    parameter int unsigned FLOOR_Y      = ScreenH - 1,
    parameter int unsigned WIN_SCORE    = 10
) (
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    start,
    input  logic [9:0]              BallX,
    input  logic [9:0]              BallY,
    input  logic [9:0]              BallWidth,
    input  logic [9:0]              BallHeight,
    output logic [NUM_PIPES*10-1:0] PipeX,
    output logic [NUM_PIPES*10-1:0] GapY,
    output logic [7:0]              score,
    output logic                    playing,
    output logic                    gameover,
    output logic                    gamewin
);

    localparam int unsigned WrapAdd = NUM_PIPES * PIPE_SPACING;

    // Home position can exceed 10 bits (e.g. 1080), so pipe X is kept in 11 bits.
    function automatic logic [10:0] home_x(input int unsigned i);
        return 11'(SCREEN_W + i * PIPE_SPACING);
    endfunction

    game_state_e          state_q, state_d;
    logic                 start_q, start_edge;
    logic [7:0]           lfsr;
    logic [10:0]          step;

    logic [10:0]          pipe_x_q   [NUM_PIPES];
    logic [10:0]          pipe_x_d   [NUM_PIPES];
    logic [10:0]          pipe_x_nxt [NUM_PIPES];
    logic [9:0]           gap_y_q    [NUM_PIPES];
    logic [9:0]           gap_y_d    [NUM_PIPES];
    logic [9:0]           gap_y_nxt  [NUM_PIPES];
    logic [NUM_PIPES-1:0] passed_q, passed_d, passed_nxt;
    logic [7:0]           score_q, score_d, score_play;

    logic [2:0]           pass_cnt;
    logic                 hit, wrap_seen;
    logic [10:0]          ball_x, ball_x_end, ball_y_end;
    logic [10:0]          pipe_r, gap_top, gap_end;
    logic [6:0]           rand7;

    logic                 playing_q, gameover_q, gamewin_q;
    logic                 playing_d, gameover_d, gamewin_d;

    assign start_edge = start & ~start_q;

    lfsr8 u_lfsr (
        .clk   (frame_clk),
        .Reset (Reset),
        .en    (1'b1),
        .seed  (LfsrSeed),
        .state (lfsr)
    );

    // Effective scroll step for this frame.
    always_comb begin
`ifdef PIPE_SPEEDUP_EN
        step = 11'(SCROLL_STEP) + {5'd0, score_q[7:2]};
        if (step > 11'(2 * SCROLL_STEP)) begin
            step = 11'(2 * SCROLL_STEP);
        end
`else
        step = 11'(SCROLL_STEP);
`endif
    end

    // Per-pipe move/wrap, pass counting and collision detection.
    // "End" values are one past the last pixel so a zero-size box cannot underflow.
    always_comb begin
        hit        = 1'b0;
        pass_cnt   = '0;
        wrap_seen  = 1'b0;
        passed_nxt = passed_q;
        pipe_r     = '0;
        gap_top    = '0;
        gap_end    = '0;
        rand7      = '0;
        ball_x     = {1'b0, BallX};
        ball_x_end = {1'b0, BallX} + {1'b0, BallWidth};
        ball_y_end = {1'b0, BallY} + {1'b0, BallHeight};
        for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_x_nxt[i] = pipe_x_q[i];
            gap_y_nxt[i]  = gap_y_q[i];
        end

        if (ball_y_end > 11'(FLOOR_Y)) begin
            hit = 1'b1;
        end

        for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_r  = pipe_x_q[i] + 11'(PIPE_W - 1);
            gap_top = {1'b0, gap_y_q[i]};
            gap_end = gap_top + 11'(GAP_H);

            if ((ball_x <= pipe_r) && (ball_x_end > pipe_x_q[i]) &&
                (({1'b0, BallY} < gap_top) || (ball_y_end > gap_end))) begin
                hit = 1'b1;
            end

            if (!passed_q[i] && (pipe_r < ball_x)) begin
                passed_nxt[i] = 1'b1;
                pass_cnt      = pass_cnt + 3'd1;
            end

            if (pipe_x_q[i] < step) begin
                pipe_x_nxt[i] = pipe_x_q[i] + 11'(WrapAdd) - step;
                // Later wrappers in the same frame get a rotated value so gaps differ.
                rand7         = wrap_seen ? rot_low7(lfsr, 32'(i)) : lfsr[6:0];
                gap_y_nxt[i]  = 10'(GAP_MIN) + {3'd0, rand7};
                passed_nxt[i] = 1'b0;
                wrap_seen     = 1'b1;
            end else begin
                pipe_x_nxt[i] = pipe_x_q[i] - step;
            end
        end

        score_play = score_q + {5'd0, pass_cnt};
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_edge) state_d = StPlay;
            StPlay: begin
                if (hit) begin
                    state_d = StOver;
                end else if (32'(score_play) >= WIN_SCORE) begin
                    state_d = StWin;
                end
            end
            StOver, StWin: if (start_edge) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: datapath register loads and next-frame flags.
    always_comb begin
        pipe_x_d = pipe_x_q;
        gap_y_d  = gap_y_q;
        passed_d = passed_q;
        score_d  = score_q;
        unique case (state_q)
            StIdle: begin
                for (int i = 0; i < NUM_PIPES; i++) begin
                    pipe_x_d[i] = home_x(32'(i));
                    gap_y_d[i]  = 10'(GAP_MIN);
                end
                passed_d = '0;
                score_d  = '0;
            end
            StPlay: begin
                // A hit freezes the field at its pre-hit picture.
                if (!hit) begin
                    pipe_x_d = pipe_x_nxt;
                    gap_y_d  = gap_y_nxt;
                    passed_d = passed_nxt;
                    score_d  = score_play;
                end
            end
            default: ;
        endcase
        playing_d  = (state_d == StPlay);
        gameover_d = (state_d == StOver);
        gamewin_d  = (state_d == StWin);
    end

    // FSM state, start edge history and flag registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            start_q    <= 1'b1;
            playing_q  <= 1'b0;
            gameover_q <= 1'b0;
            gamewin_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            playing_q  <= playing_d;
            gameover_q <= gameover_d;
            gamewin_q  <= gamewin_d;
        end
    end

    // Pipe field and score registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x_q[i] <= home_x(32'(i));
                gap_y_q[i]  <= 10'(GAP_MIN);
            end
            passed_q <= '0;
            score_q  <= '0;
        end else begin
            pipe_x_q <= pipe_x_d;
            gap_y_q  <= gap_y_d;
            passed_q <= passed_d;
            score_q  <= score_d;
        end
    end

    // Pack outputs; pipes parked beyond 10-bit range read as 1023 (off screen).
    always_comb begin
        PipeX = '0;
        GapY  = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            PipeX[10*i +: 10] = pipe_x_q[i][10] ? 10'h3FF : pipe_x_q[i][9:0];
            GapY[10*i +: 10]  = gap_y_q[i];
        end
    end

    assign score    = score_q;
    assign playing  = playing_q;
    assign gameover = gameover_q;
    assign gamewin  = gamewin_q;

endmodule

// File: tb/tb_pipe_referee.sv
// tb_pipe_referee: directed, table-driven bench for pipe_referee (WIN_SCORE=2).
module tb_pipe_referee;

    logic        Reset, frame_clk, start;
    logic [9:0]  BallX, BallY, BallWidth, BallHeight;
    logic [29:0] PipeX, GapY;
    logic [7:0]  score;
    logic        playing, gameover, gamewin;

    int checks   = 0;
    int failures = 0;

    logic [7:0] lfsr_m;
    int         exp_gap;

    typedef struct {
        int frames;
        int st;
        int bx, by, bw, bh;
        int x0, x1, sc, fl;
    } vec_t;

    vec_t tbl[$];

    pipe_referee #(.WIN_SCORE(2)) dut (
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .start      (start),
        .BallX      (BallX),
        .BallY      (BallY),
        .BallWidth  (BallWidth),
        .BallHeight (BallHeight),
        .PipeX      (PipeX),
        .GapY       (GapY),
        .score      (score),
        .playing    (playing),
        .gameover   (gameover),
        .gamewin    (gamewin)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Reference LFSR: seed A5, right-shift Galois with mask B8, steps every frame.
    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) lfsr_m <= 8'hA5;
        else       lfsr_m <= {1'b0, lfsr_m[7:1]} ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic add(input int f, input int st, input int bx, input int by, input int bw,
                       input int bh, input int x0, input int x1, input int sc, input int fl);
        tbl.push_back('{f, st, bx, by, bw, bh, x0, x1, sc, fl});
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            start      = tbl[i].st[0];
            BallX      = 10'(tbl[i].bx);
            BallY      = 10'(tbl[i].by);
            BallWidth  = 10'(tbl[i].bw);
            BallHeight = 10'(tbl[i].bh);
            tick(tbl[i].frames);
            check($sformatf("v%0d_pipex0", i), int'(PipeX[9:0]), tbl[i].x0);
            check($sformatf("v%0d_pipex1", i), int'(PipeX[19:10]), tbl[i].x1);
            check($sformatf("v%0d_score", i), int'(score), tbl[i].sc);
            check($sformatf("v%0d_flags", i), int'({playing, gameover, gamewin}), tbl[i].fl);
        end
    endtask

    // Flags: 4 = playing, 2 = gameover, 1 = gamewin.
    initial begin
        // Game 1: ball low (Y 260..299, X 30..74) -> pipe 0 hits when it reaches X=74.
        add(3,   1, 30, 260, 45, 40, 640, 860, 0, 0);  // 0: key held through reset
        add(1,   0, 30, 260, 45, 40, 640, 860, 0, 0);  // 1
        add(1,   1, 30, 260, 45, 40, 640, 860, 0, 4);  // 2: edge -> PLAY
        add(1,   1, 30, 260, 45, 40, 638, 858, 0, 4);  // 3: first move
        add(281, 1, 30, 260, 45, 40,  76, 296, 0, 4);  // 4
        add(1,   1, 30, 260, 45, 40,  74, 294, 0, 4);  // 5: overlap begins
        add(1,   1, 30, 260, 45, 40,  74, 294, 0, 2);  // 6: hit, frozen
        add(2,   1, 30, 260, 45, 40,  74, 294, 0, 2);  // 7
        // Game 2: ball in gap at X 300..319, two passes win.
        add(1,   0, 300, 150, 20, 40,  74, 294, 0, 2); // 8
        add(2,   1, 300, 150, 20, 40, 640, 860, 0, 0); // 9: -> IDLE, reinit
        add(1,   0, 300, 150, 20, 40, 640, 860, 0, 0); // 10
        add(1,   1, 300, 150, 20, 40, 640, 860, 0, 4); // 11
        add(190, 1, 300, 150, 20, 40, 260, 480, 0, 4); // 12: 260+39 < 300 now
        add(1,   1, 300, 150, 20, 40, 258, 478, 1, 4); // 13: first pass
        add(9,   1, 300, 150, 20, 40, 240, 460, 1, 4); // 14: counted once
        add(100, 1, 300, 150, 20, 40,  40, 260, 1, 4); // 15
        add(1,   1, 300, 150, 20, 40,  38, 258, 2, 1); // 16: second pass -> WIN
        add(2,   1, 300, 150, 20, 40,  38, 258, 2, 1); // 17
        // Game 3: ball in gap, no passes; pipe 0 wraps, then floor boundary.
        add(1,   0, 30, 150, 45, 40,  38, 258, 2, 1);  // 18
        add(2,   1, 30, 150, 45, 40, 640, 860, 0, 0);  // 19
        add(1,   0, 30, 150, 45, 40, 640, 860, 0, 0);  // 20
        add(1,   1, 30, 150, 45, 40, 640, 860, 0, 4);  // 21
        add(320, 1, 30, 150, 45, 40,   0, 220, 0, 4);  // 22
        add(1,   1, 30, 439, 45, 40, 654, 214, 0, 4);  // 23: bottom 478, safe
        add(1,   1, 30, 440, 45, 40, 654, 214, 0, 2);  // 24: bottom 479, crash
        add(1,   1, 30, 440, 45, 40, 654, 214, 0, 2);  // 25
        // Game 4: winning pass and floor crash in the same frame.
        add(1,   0, 300, 150, 20, 40, 654, 214, 0, 2); // 26
        add(2,   1, 300, 150, 20, 40, 640, 860, 0, 0); // 27
        add(1,   0, 300, 150, 20, 40, 640, 860, 0, 0); // 28
        add(1,   1, 300, 150, 20, 40, 640, 860, 0, 4); // 29
        add(191, 1, 300, 150, 20, 40, 258, 478, 1, 4); // 30
        add(109, 1, 300, 150, 20, 40,  40, 260, 1, 4); // 31
        add(1,   1, 300, 440, 20, 40,  40, 260, 1, 2); // 32: OVER, score stays 1

        Reset = 1'b1;
        start = 1'b1;
        BallX = 10'd30; BallY = 10'd260; BallWidth = 10'd45; BallHeight = 10'd40;
        tick(2);
        check("rst_pipex0", int'(PipeX[9:0]), 640);
        check("rst_pipex1", int'(PipeX[19:10]), 860);
        check("rst_gapy0", int'(GapY[9:0]), 100);
        check("rst_gapy1", int'(GapY[19:10]), 100);
        check("rst_gapy2", int'(GapY[29:20]), 100);
        check("rst_score", int'(score), 0);
        check("rst_flags", int'({playing, gameover, gamewin}), 0);
        Reset = 1'b0;

        run(0, 22);

        // Pipe 0 sits at X=0 < step: wraps to 0+660-2 with a fresh gap.
        exp_gap = 100 + int'(lfsr_m[6:0]);
        tick(1);
        check("wrap_pipex0", int'(PipeX[9:0]), 658);
        check("wrap_gapy0", int'(GapY[9:0]), exp_gap);
        check("wrap_pipex1", int'(PipeX[19:10]), 218);
        check("wrap_gapy1", int'(GapY[19:10]), 100);
        tick(1);
        check("wrap_next_pipex0", int'(PipeX[9:0]), 656);
        check("wrap_next_gapy0", int'(GapY[9:0]), exp_gap);

        run(23, 32);
        check("g4_gapy0", int'(GapY[9:0]), 100);

        // Asynchronous reset in the middle of a game.
        Reset = 1'b1;
        #2;
        check("async_rst_pipex0", int'(PipeX[9:0]), 640);
        check("async_rst_pipex1", int'(PipeX[19:10]), 860);
        check("async_rst_score", int'(score), 0);
        check("async_rst_flags", int'({playing, gameover, gamewin}), 0);
        Reset = 1'b0;
        tick(2);
        check("post_rst_held_key", int'({playing, gameover, gamewin}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
